// File: rtl/input_conditioner.sv
// input_conditioner
//   Synchronizes and debounces the exec key, reset key and four slide
//   switches. It then produces one-clock press pulses for the keys and
//   debounced levels for the switches.
//
//   Optional feature: define INPUT_CONDITIONER_REPEAT_EN to make a held exec
//   key auto-repeat its pulse every REPEAT_CYCLES clocks.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   keyExec    in   raw exec button, active-low, asynchronous
//   keyReset   in   raw reset button, active-low, asynchronous
//   sw[3:0]    in   raw slide switches, active-high, asynchronous
//   exec       out  one-clock pulse per debounced exec press
//   resetPulse out  one-clock pulse per debounced reset press
//   in[3:0]    out  debounced switch levels
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       keyExec,
   input  logic       keyReset,
   input  logic [3:0] sw,
   output logic       exec,
   output logic       resetPulse,
   output logic [3:0] in
);

   localparam int NCH = 6;  // 0: exec key, 1: reset key, 2..5: sw[3:0]
   // The keys idle high (released), so their synchronizer flops reset to 1.
   localparam logic [NCH-1:0] REL_LEVEL = 6'b00_0011;
   localparam logic [19:0]    DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);

   logic [NCH-1:0] raw, sync1, sync2, sync_val, stable;
   logic [1:0]     key_stable_q;
   logic           exec_fire;

   assign raw = {sw, keyReset, keyExec};

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= REL_LEVEL;
         sync2 <= REL_LEVEL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Keys are inverted after synchronization, so 1 means pressed.
   assign sync_val = sync2 ^ REL_LEVEL;

   // Per-channel debounce. The stable value only follows the synchronized
   // input after DEBOUNCE_CYCLES consecutive disagreeing samples. Any
   // agreement restarts the count.
   for (genvar ch = 0; ch < NCH; ch++) begin : g_db
      logic [19:0] cnt;
      logic        stb;

      always_ff @(posedge clock) begin
         if (reset) begin
            cnt <= '0;
            stb <= 1'b0;
         end else if (sync_val[ch] == stb) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            stb <= sync_val[ch];
            cnt <= '0;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end

      assign stable[ch] = stb;
   end

`ifdef INPUT_CONDITIONER_REPEAT_EN
   localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);
   logic [23:0] rep_cnt;

   // Fire on the press edge. Also fire each time the held key has run a
   // full repeat period since the last pulse.
   assign exec_fire = (stable[0] & ~key_stable_q[0]) |
                      (stable[0] && rep_cnt == REP_LAST);

   always_ff @(posedge clock) begin
      if (reset || !stable[0] || exec_fire) rep_cnt <= '0;
      else                                  rep_cnt <= rep_cnt + 24'd1;
   end
`else
   assign exec_fire = stable[0] & ~key_stable_q[0];
`endif

   // The outputs are registered one stage after the stable values, so the
   // pulses and the switch levels all update on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         key_stable_q <= '0;
         exec         <= 1'b0;
         resetPulse   <= 1'b0;
         in           <= '0;
      end else begin
         key_stable_q <= stable[1:0];
         exec         <= exec_fire;
         resetPulse   <= stable[1] & ~key_stable_q[1];
         in           <= stable[5:2];
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

   localparam int D = 4;
   localparam int R = 8;

   logic       clock = 1'b0;
   logic       reset, keyExec, keyReset;
   logic [3:0] sw;
   logic       exec, resetPulse;
   logic [3:0] in;

   input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
      .clock(clock), .reset(reset), .keyExec(keyExec), .keyReset(keyReset),
      .sw(sw), .exec(exec), .resetPulse(resetPulse), .in(in)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       ex;
      logic       rp;
      logic [3:0] lv;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0, fails = 0;
   int   exec_seen = 0, rp_seen = 0;
   bit   done = 1'b0;

   // Reference model. Channel values are in "asserted" polarity: keys are
   // 1 = pressed, and switches are 1 = on.
   bit m_d1[6], m_d2[6], m_stb[6];
   int m_run[6];      // consecutive synchronized samples that differ from the stable value
   int m_h0, m_h1;    // edges for which the exec/reset key has been stably pressed

   task automatic model_edge(input bit r, input bit ke, input bit kr, input bit [3:0] s,
                             output exp_t e);
      bit raw_a[6];
      int hn;
      raw_a[0] = ~ke; raw_a[1] = ~kr;
      for (int i = 0; i < 4; i++) raw_a[2+i] = s[i];
      if (r) begin
         for (int i = 0; i < 6; i++) begin
            m_d1[i] = 0; m_d2[i] = 0; m_stb[i] = 0; m_run[i] = 0;
         end
         m_h0 = 0; m_h1 = 0;
         e.ex = 0; e.rp = 0; e.lv = '0;
      end else begin
         hn = m_stb[0] ? m_h0 + 1 : 0;
`ifdef INPUT_CONDITIONER_REPEAT_EN
         e.ex = m_stb[0] && ((hn - 1) % R == 0);
`else
         e.ex = m_stb[0] && (hn == 1);
`endif
         m_h0 = hn;
         hn = m_stb[1] ? m_h1 + 1 : 0;
         e.rp = m_stb[1] && (hn == 1);
         m_h1 = hn;
         e.lv = {m_stb[5], m_stb[4], m_stb[3], m_stb[2]};
         for (int i = 0; i < 6; i++) begin
            if (m_d2[i] == m_stb[i]) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == D) begin m_stb[i] = m_d2[i]; m_run[i] = 0; end
            end
            m_d2[i] = m_d1[i];
            m_d1[i] = raw_a[i];
         end
      end
   endtask

   // Drive one clock worth of inputs (sampled at the next rising edge) and
   // queue the expected outputs after that edge.
   task automatic step(input bit r, input bit ke, input bit kr, input bit [3:0] s);
      exp_t e;
      reset = r; keyExec = ke; keyReset = kr; sw = s;
      model_edge(r, ke, kr, s, e);
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   task automatic hold(input int n, input bit ke, input bit kr, input bit [3:0] s);
      for (int i = 0; i < n; i++) step(1'b0, ke, kr, s);
   endtask

   task automatic check_count(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every cycle presents an output, so pop one expectation per edge.
   always @(posedge clock) begin
      #1;
      if (!done) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL underflow: no expectation queued at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (exec !== e.ex || resetPulse !== e.rp || in !== e.lv) begin
               fails++;
               $display("FAIL outputs @%0t: exec=%b resetPulse=%b in=%b expected exec=%b resetPulse=%b in=%b",
                        $time, exec, resetPulse, in, e.ex, e.rp, e.lv);
            end
         end
         if (exec === 1'b1) exec_seen++;
         if (resetPulse === 1'b1) rp_seen++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, r0;
      bit ke, kr;
      bit [3:0] s;

      // Reset state.
      step(1'b1, 1, 1, 4'h0);
      step(1'b1, 1, 1, 4'h0);
      hold(3, 1, 1, 4'h0);

      // A held exec press gives a single pulse.
      c0 = exec_seen;
      hold(12, 0, 1, 4'h0);
      hold(10, 1, 1, 4'h0);
`ifndef INPUT_CONDITIONER_REPEAT_EN
      check_count("single_press", exec_seen - c0, 1);
`endif

      // A press that is too short gives no pulse.
      c0 = exec_seen;
      hold(3, 0, 1, 4'h0);
      hold(10, 1, 1, 4'h0);
      check_count("short_press", exec_seen - c0, 0);

      // Switch level, then a one-clock glitch.
      hold(10, 1, 1, 4'b1010);
      hold(1, 1, 1, 4'b0000);
      hold(10, 1, 1, 4'b1010);
      hold(10, 1, 1, 4'b0000);

      // Exec and reset pressed at the same edge.
      c0 = exec_seen; r0 = rp_seen;
      hold(10, 0, 0, 4'h0);
      hold(10, 1, 1, 4'h0);
      check_count("dual_exec", exec_seen - c0, 1);
      check_count("dual_reset", rp_seen - r0, 1);

      // Reset in the middle of a debounce, with the key still held.
      c0 = exec_seen;
      hold(3, 0, 1, 4'h0);
      step(1'b1, 0, 1, 4'h0);
      hold(12, 0, 1, 4'h0);
      hold(10, 1, 1, 4'h0);
`ifndef INPUT_CONDITIONER_REPEAT_EN
      check_count("reset_mid_press", exec_seen - c0, 1);
`endif

`ifdef INPUT_CONDITIONER_REPEAT_EN
      // Auto-repeat while held.
      c0 = exec_seen;
      hold(40, 0, 1, 4'h0);
      hold(12, 1, 1, 4'h0);
      check_count("repeat_held", exec_seen - c0, 5);
`endif

      // Random stimulus: mostly steady inputs with occasional flips, so
      // both full debounces and glitches occur, plus rare resets.
      ke = 1; kr = 1; s = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         int pick;
         pick = int'($urandom_range(0, 63));
         if (pick == 0) ke = ~ke;
         else if (pick == 1) kr = ~kr;
         else if (pick < 6) s[pick-2] = ~s[pick-2];
         step($urandom_range(0, 399) == 0, ke, kr, s);
      end
      hold(20, 1, 1, 4'h0);

      // Drain the queue, then stop the monitor.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
      check_count("queue_drained", exp_q.size(), 0);
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive clocks a synchronized input must differ from its stable value before the stable value changes (10 ms at 50 MHz); legal range 1 to 2^20-1.
REQ-002 Parameter REPEAT_CYCLES, default 12500000, auto-repeat period in clocks (250 ms at 50 MHz); legal range 1 to 2^24-1; used only when INPUT_CONDITIONER_REPEAT_EN is defined.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 keyExec  input  1  raw exec push-button, active-low (0 = pressed), asynchronous to clock.
REQ-006 keyReset  input  1  raw reset push-button, active-low, asynchronous to clock.
REQ-007 sw  input  4  raw slide switches, active-high, asynchronous to clock.
REQ-008 exec  output  1  one-clock pulse per debounced exec press; drives the controller's exec input.
REQ-009 resetPulse  output  1  one-clock pulse per debounced reset press; drives the controller's reset input.
REQ-010 in  output  4  debounced switch levels; drives the controller's in input.

Function
REQ-011 Six channels (exec key, reset key, sw[3:0]) shall each have a two-flop synchronizer followed by an independent debounce counter (20 bits) and a stable-value register.
REQ-012 Key channels shall be inverted after synchronization so stable value 1 means pressed.
REQ-013 Each cycle: synchronized == stable -> counter <= 0; synchronized != stable and counter == DEBOUNCE_CYCLES-1 -> stable <= synchronized, counter <= 0; otherwise counter <= counter+1.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall not change the stable value; the counter restarts from 0 at the next disagreement.
REQ-015 exec/resetPulse shall be registered and high for exactly one clock, in the cycle after the edge at which the channel's stable value goes 0->1; release (1->0) shall produce no pulse.
REQ-016 Latency: with raw input held, pulse is high in the cycle following clock edge 2+DEBOUNCE_CYCLES, counting the first edge that samples the new raw level as edge 0; in[n] changes at that same edge.
REQ-017 in shall equal the stable values of sw[3:0] directly (no pulse shaping).
REQ-018 Channels are independent; simultaneous exec and reset presses shall produce pulses in the same cycle, with no arbitration in this block.
REQ-019 A held key shall generate no further pulses unless INPUT_CONDITIONER_REPEAT_EN is defined.

Reset
REQ-020 While reset is high: synchronizer flops <= released/0 level (keys 0 after inversion, sw 0), counters <= 0, stable values <= 0, exec <= 0, resetPulse <= 0, in <= 4'b0000, repeat counter <= 0.
REQ-021 Reset asserted mid-debounce shall discard the partial count; a key held through reset release shall produce one pulse per REQ-016, timed from the first post-reset edge.
REQ-022 resetPulse shall not feed back into this block's reset port.

Configuration
REQ-023 Macro INPUT_CONDITIONER_REPEAT_EN defined: the exec channel gets a 24-bit repeat counter, cleared whenever exec stable is 0 or a pulse is issued, incremented while stable is 1; on reaching REPEAT_CYCLES-1 it issues one additional exec pulse and clears, repeating while held.
REQ-024 Macro undefined: no repeat counter is synthesized, and exactly one exec pulse is issued per press; resetPulse never auto-repeats in either build.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-025 After reset, keyExec 1->0 sampled at edge 0 and held -> exec high only during the cycle after edge 6, low thereafter (repeat macro undefined).
REQ-026 keyExec low for 3 clocks then high -> exec stays 0; counter returns to 0; no change to in.
REQ-027 sw=4'b1010 applied and held -> in == 4'b1010 after edge 6, 4'b0000 before it; one-clock sw glitch -> in unchanged.
REQ-028 keyExec and keyReset pressed at the same edge -> exec and resetPulse both high in the same single cycle.
REQ-029 reset pulsed at edge 3 of a press -> no pulse at edge 6; pulse after 2+4 edges counted from reset release.
REQ-030 REPEAT_EN defined, keyExec held 40 clocks -> first pulse after edge 6, then one pulse every 8 clocks while held; none after release.
